// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator (hsync/vsync/blanking/pixel position)
//
// Purpose: walks an (h,v) raster of H_tot x V_tot pixel clocks and produces
// registered sync, blanking and position outputs that all describe the same
// position (zero skew between outputs).
//
// Optional feature: define VTG_FRAME_CNT_EN to add a 16-bit frame counter.
//
// Ports:
//   clk         pixel clock
//   rst         asynchronous active-low reset
//   en          count enable; 0 freezes all state (sol/sof forced to 0)
//   hsync       horizontal sync, active level HS_POL
//   vsync       vertical sync, active level VS_POL
//   blank_n     0 during blanking (same as disp_enable)
//   sync_n      composite sync, active-low regardless of polarity params
//   disp_enable 1 inside the active video area
//   Xpix, Ypix  current column / line inside the active area, 0 in blanking
//   sol, sof    start-of-line / start-of-frame pulses
//   frame_cnt   (VTG_FRAME_CNT_EN only) frames completed, modulo 2^16
module video_timing_gen #(
  parameter int CW      = 11,
  parameter int H_disp  = 640,
  parameter int H_front = 16,
  parameter int H_sync  = 96,
  parameter int H_back  = 48,
  parameter int V_disp  = 480,
  parameter int V_front = 10,
  parameter int V_sync  = 2,
  parameter int V_back  = 33,
  parameter int HS_POL  = 0,
  parameter int VS_POL  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          blank_n,
  output logic          sync_n,
  output logic          disp_enable,
  output logic [CW-1:0] Xpix,
  output logic [CW-1:0] Ypix,
  output logic          sol,
  output logic          sof
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int H_tot = H_disp + H_front + H_sync + H_back;
  localparam int V_tot = V_disp + V_front + V_sync + V_back;

  // Refuse to build if the counters cannot reach the last position.
  if ((H_tot - 1) >= (1 << CW) || (V_tot - 1) >= (1 << CW)) begin : g_cw_too_small
    $error("video_timing_gen: CW too narrow for H_tot/V_tot");
  end

  // Sized copies of the window boundaries so every compare is CW bits wide.
  localparam logic [CW-1:0] H_LAST   = CW'(H_tot - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_tot - 1);
  localparam logic [CW-1:0] H_DISP_W = CW'(H_disp);
  localparam logic [CW-1:0] V_DISP_W = CW'(V_disp);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_disp + H_front);
  localparam logic [CW-1:0] HS_END   = CW'(H_disp + H_front + H_sync);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_disp + V_front);
  localparam logic [CW-1:0] VS_END   = CW'(V_disp + V_front + V_sync);
  localparam logic          HS_ACT   = 1'(HS_POL);
  localparam logic          VS_ACT   = 1'(VS_POL);

  logic [CW-1:0] h, v;
  logic [CW-1:0] h_nxt, v_nxt;
  logic          h_wrap, v_wrap;
  logic          de_nxt, hs_win, vs_win;

  // Outputs are decoded from the position the counters move to on this edge,
  // so the registered outputs line up with the registered counters.
  always_comb begin
    h_wrap = (h == H_LAST);
    v_wrap = (v == V_LAST);
    h_nxt  = h_wrap ? '0 : h + CW'(1);
    v_nxt  = v;
    if (h_wrap) begin
      v_nxt = v_wrap ? '0 : v + CW'(1);
    end
    de_nxt = (h_nxt < H_DISP_W) && (v_nxt < V_DISP_W);
    hs_win = (h_nxt >= HS_BEG) && (h_nxt < HS_END);
    vs_win = (v_nxt >= VS_BEG) && (v_nxt < VS_END);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h           <= '0;
      v           <= '0;
      hsync       <= ~HS_ACT;
      vsync       <= ~VS_ACT;
      sync_n      <= 1'b1;
      blank_n     <= 1'b0;
      disp_enable <= 1'b0;
      Xpix        <= '0;
      Ypix        <= '0;
      sol         <= 1'b0;
      sof         <= 1'b0;
    end else if (en) begin
      h           <= h_nxt;
      v           <= v_nxt;
      hsync       <= hs_win ? HS_ACT : ~HS_ACT;
      vsync       <= vs_win ? VS_ACT : ~VS_ACT;
      sync_n      <= ~(hs_win | vs_win);
      blank_n     <= de_nxt;
      disp_enable <= de_nxt;
      Xpix        <= de_nxt ? h_nxt : '0;
      Ypix        <= de_nxt ? v_nxt : '0;
      sol         <= (h_nxt == '0);
      sof         <= (h_nxt == '0) && (v_nxt == '0);
    end else begin
      // Frozen: everything holds except the pulses, which must not stretch.
      sol <= 1'b0;
      sof <= 1'b0;
    end
  end

`ifdef VTG_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
    end else if (en && h_wrap && v_wrap) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule
